// File: rtl/vc_input_buffer_onoff_pkg.sv
// Router-wide constants, types and the on/off hysteresis rule shared by the
// per-VC input buffers.
package vc_input_buffer_onoff_pkg;

    localparam int VC_NUM    = 4;
    localparam int FLIT_W    = 64;
    localparam int DEPTH_DEF = 8;

    // Flits that can still arrive after on_off is raised: one cycle for the
    // registered stop signal to reach the upstream allocator, one for the
    // flit already on the wire.
    localparam int LINK_RTT = 2;

    // Stop early enough that in-flight flits still fit, and resume once the
    // buffer has drained to the same margin so the pipe refills without a gap.
    localparam int OFF_THRESH_DEF = DEPTH_DEF - LINK_RTT;
    localparam int ON_THRESH_DEF  = LINK_RTT;

    typedef logic [FLIT_W-1:0]          flit_t;
    typedef logic [$clog2(VC_NUM)-1:0]  vc_id_t;

    // Hysteresis: raise at or above the off threshold, drop at or below the
    // on threshold, otherwise keep the current state.
    function automatic logic onoff_next(input logic cur, input int level,
                                        input int off_t, input int on_t);
        if (!cur && level >= off_t) return 1'b1;
        if (cur && level <= on_t)   return 1'b0;
        return cur;
    endfunction

endpackage

// File: rtl/vc_input_buffer_onoff_fifo.sv
// Single-VC first-word-fall-through FIFO with occupancy count and a
// registered on/off stop flag driven by occupancy hysteresis.
module vc_onoff_fifo
    import vc_input_buffer_onoff_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 8,
    parameter int OFF_THRESH = 6,
    parameter int ON_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       on_off
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       cnt;
    logic [AW:0]       cnt_nxt;
    logic              push_ok;
    logic              pop_ok;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);

    // A pop in the same cycle frees the slot, so a write to a full VC with a
    // concurrent read is accepted.
    assign push_ok = wr_en && (!full || rd_en);
    assign pop_ok  = rd_en && !empty;
    assign cnt_nxt = cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);

    assign head  = mem[rptr];
    assign count = cnt;

    // Storage: data slots are not reset; the count guards their validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wr_data;
    end

    // Pointers, occupancy and the stop flag, which sees post-update occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt    <= '0;
            on_off <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            cnt    <= cnt_nxt;
            on_off <= onoff_next(on_off, int'(cnt_nxt), OFF_THRESH, ON_THRESH);
        end
    end

endmodule

// File: rtl/vc_input_buffer_onoff.sv
// Per-port input buffer: one FWFT FIFO per virtual channel, a registered
// per-VC on/off stop signal back to the upstream router, and registered
// overflow/underflow pulses.
module vc_input_buffer_onoff #(
    parameter int VC_NUM     = vc_input_buffer_onoff_pkg::VC_NUM,
    parameter int FLIT_W     = vc_input_buffer_onoff_pkg::FLIT_W,
    parameter int DEPTH      = vc_input_buffer_onoff_pkg::DEPTH_DEF,
    parameter int OFF_THRESH = vc_input_buffer_onoff_pkg::OFF_THRESH_DEF,
    parameter int ON_THRESH  = vc_input_buffer_onoff_pkg::ON_THRESH_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [$clog2(VC_NUM)-1:0]        wr_vc,
    input  logic [FLIT_W-1:0]                wr_flit,
    input  logic [VC_NUM-1:0]                rd_en,
    output logic [VC_NUM-1:0][FLIT_W-1:0]    head_flit,
    output logic [VC_NUM-1:0]                head_valid,
    output logic [VC_NUM-1:0]                on_off,
    output logic                             overflow_err,
    output logic                             underflow_err
);

    import vc_input_buffer_onoff_pkg::*;

    localparam int CW = $clog2(DEPTH);

    logic [VC_NUM-1:0]         wr_sel;
    logic [VC_NUM-1:0]         vc_empty;
    logic [VC_NUM-1:0]         vc_full;
    logic [VC_NUM-1:0][CW:0]   vc_count;
    logic                      ovf_now;
    logic                      unf_now;

    // Decode the target VC; an out-of-range VC selects nothing.
    always_comb begin
        wr_sel = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (wr_en && (int'(wr_vc) == v)) wr_sel[v] = 1'b1;
        end
    end

    // A dropped write is either an invalid VC or a full VC with no pop.
    assign ovf_now = (wr_en && !(|wr_sel)) || (|(wr_sel & vc_full & ~rd_en));
    assign unf_now = |(rd_en & vc_empty);

    for (genvar gv = 0; gv < VC_NUM; gv++) begin : g_vc
        vc_onoff_fifo #(
            .DATA_W     (FLIT_W),
            .DEPTH      (DEPTH),
            .OFF_THRESH (OFF_THRESH),
            .ON_THRESH  (ON_THRESH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_sel[gv]),
            .wr_data (wr_flit),
            .rd_en   (rd_en[gv]),
            .head    (head_flit[gv]),
            .count   (vc_count[gv]),
            .empty   (vc_empty[gv]),
            .full    (vc_full[gv]),
            .on_off  (on_off[gv])
        );
        assign head_valid[gv] = (vc_count[gv] != '0);
    end

    // Error pulses: one registered cycle, merged across all VCs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow_err  <= ovf_now;
            underflow_err <= unf_now;
        end
    end

endmodule

// File: tb/tb_vc_input_buffer_onoff.sv
// Bench for vc_input_buffer_onoff: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the buffer.
module tb_vc_input_buffer_onoff;

    localparam int NV  = 4;
    localparam int FW  = 64;
    localparam int DEP = 8;
    localparam int OFF = 6;
    localparam int ON  = 2;

    logic                   clk;
    logic                   reset;
    logic                   wr_en;
    logic [1:0]             wr_vc;
    logic [FW-1:0]          wr_flit;
    logic [NV-1:0]          rd_en;
    logic [NV-1:0][FW-1:0]  head_flit;
    logic [NV-1:0]          head_valid;
    logic [NV-1:0]          on_off;
    logic                   overflow_err;
    logic                   underflow_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one queue per VC, stop flags, expected error pulses.
    logic [FW-1:0] q [NV][$];
    bit   [NV-1:0] stop_m;
    bit            ovf_m;
    bit            unf_m;

    vc_input_buffer_onoff dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_vc         (wr_vc),
        .wr_flit       (wr_flit),
        .rd_en         (rd_en),
        .head_flit     (head_flit),
        .head_valid    (head_valid),
        .on_off        (on_off),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++) q[v].delete();
        stop_m = '0;
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
    endtask

    // Apply one edge's worth of traffic to the model from the current inputs.
    task automatic model_step();
        bit [NV-1:0] pop;
        ovf_m = 1'b0;
        unf_m = 1'b0;
        for (int v = 0; v < NV; v++) begin
            pop[v] = rd_en[v] && (q[v].size() > 0);
            if (rd_en[v] && q[v].size() == 0) unf_m = 1'b1;
        end
        for (int v = 0; v < NV; v++) if (pop[v]) void'(q[v].pop_front());
        if (wr_en) begin
            if (int'(wr_vc) >= NV) ovf_m = 1'b1;
            else if (q[wr_vc].size() + (pop[wr_vc] ? 1 : 0) < DEP + 1 &&
                     (q[wr_vc].size() < DEP)) q[wr_vc].push_back(wr_flit);
            else ovf_m = 1'b1;
        end
        for (int v = 0; v < NV; v++) begin
            if (q[v].size() >= OFF)     stop_m[v] = 1'b1;
            else if (q[v].size() <= ON) stop_m[v] = 1'b0;
        end
    endtask

    task automatic check_all(input string ph);
        for (int v = 0; v < NV; v++) begin
            chk($sformatf("%s hv%0d", ph, v), FW'(head_valid[v]), FW'(q[v].size() > 0));
            chk($sformatf("%s onoff%0d", ph, v), FW'(on_off[v]), FW'(stop_m[v]));
            if (q[v].size() > 0)
                chk($sformatf("%s head%0d", ph, v), head_flit[v], q[v][0]);
        end
        chk({ph, " ovf"}, FW'(overflow_err), FW'(ovf_m));
        chk({ph, " unf"}, FW'(underflow_err), FW'(unf_m));
    endtask

    // One clock: drive at the falling edge, check 1 time unit after rising.
    task automatic cycle(input string ph, input logic we, input logic [1:0] vc,
                         input logic [FW-1:0] f, input logic [NV-1:0] rd);
        wr_en   = we;
        wr_vc   = vc;
        wr_flit = f;
        rd_en   = rd;
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
        @(negedge clk);
    endtask

    initial begin
        wr_en   = 1'b0;
        wr_vc   = '0;
        wr_flit = '0;
        rd_en   = '0;
        reset   = 1'b0;
        model_clear();

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst hv", FW'(head_valid), '0);
        chk("rst onoff", FW'(on_off), '0);
        chk("rst ovf", FW'(overflow_err), '0);
        chk("rst unf", FW'(underflow_err), '0);
        reset = 1'b1;

        // Idle
        for (int i = 0; i < 10; i++) cycle("idle", 1'b0, 2'd0, '0, 4'b0000);

        // Fill VC 1 with six flits
        for (int i = 0; i < 6; i++) begin
            cycle("fill", 1'b1, 2'd1, FW'(8'h10 + i), 4'b0000);
            chk($sformatf("fill onoff1 after %0d", i + 1), FW'(on_off[1]), FW'(i == 5));
        end
        chk("fill head1", head_flit[1], 64'h10);
        chk("fill other onoff", FW'(on_off & 4'b1101), '0);

        // Drain VC 1 one flit per cycle
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("drain order %0d", i), head_flit[1], FW'(8'h10 + i));
            cycle("drain", 1'b0, 2'd0, '0, 4'b0010);
            // count after this pop is 5-i; stop holds until it reaches 2
            chk($sformatf("drain onoff1 cnt%0d", 5 - i), FW'(on_off[1]), FW'((5 - i) > 2));
        end

        // Fill VC 0 to capacity, then overflow with 0xFF
        for (int i = 0; i < 8; i++) cycle("full", 1'b1, 2'd0, FW'(8'h20 + i), 4'b0000);
        cycle("ovf", 1'b1, 2'd0, 64'hFF, 4'b0000);
        chk("ovf pulse", FW'(overflow_err), 64'h1);
        cycle("ovf idle", 1'b0, 2'd0, '0, 4'b0000);
        chk("ovf single", FW'(overflow_err), 64'h0);
        // Write and pop together at full occupancy
        cycle("full rw", 1'b1, 2'd0, 64'h30, 4'b0001);
        chk("full rw no ovf", FW'(overflow_err), 64'h0);
        chk("full rw head", head_flit[0], 64'h21);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("no FF %0d", i), FW'(head_flit[0] == 64'hFF), 64'h0);
            cycle("full drain", 1'b0, 2'd0, '0, 4'b0001);
        end
        chk("full drained", FW'(head_valid[0]), 64'h0);

        // Pop an empty VC, then write and read back
        cycle("empty pop", 1'b0, 2'd0, '0, 4'b0100);
        chk("unf pulse", FW'(underflow_err), 64'h1);
        cycle("empty wr", 1'b1, 2'd2, 64'hAA, 4'b0000);
        chk("unf single", FW'(underflow_err), 64'h0);
        chk("empty readback", head_flit[2], 64'hAA);
        cycle("empty rd", 1'b0, 2'd0, '0, 4'b0100);

        // Interleaved writes and pops on VC 3 to wrap the pointers
        for (int i = 0; i < 20; i++)
            cycle("wrap", 1'b1, 2'd3, FW'(16'h300 + i), (i >= 2) ? 4'b1000 : 4'b0000);
        for (int i = 0; i < 2; i++) cycle("wrap tail", 1'b0, 2'd0, '0, 4'b1000);

        // Random traffic across all VCs
        for (int i = 0; i < 300; i++) begin
            logic [NV-1:0] rd;
            rd = 4'($urandom) & 4'($urandom);
            cycle("rand", ($urandom_range(0, 3) != 0), 2'($urandom),
                  {$urandom, $urandom}, rd);
        end

        // Load VC 3 past the off threshold, then reset between edges
        for (int i = 0; i < 7; i++) cycle("prerst", 1'b1, 2'd3, FW'(16'h500 + i), 4'b0000);
        #2;
        reset = 1'b0;
        #1;
        chk("async hv", FW'(head_valid), '0);
        chk("async onoff", FW'(on_off), '0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;

        // Traffic after reset to confirm old flits were discarded
        cycle("postrst", 1'b1, 2'd3, 64'h77, 4'b0000);
        chk("postrst head3", head_flit[3], 64'h77);
        for (int i = 0; i < 60; i++)
            cycle("rand2", $urandom_range(0, 1) == 1, 2'($urandom),
                  {$urandom, $urandom}, 4'($urandom) & 4'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vc_input_buffer_onoff.md
Name: vc_input_buffer_onoff

Overview:
- Downstream end of the router's on/off flow-control loop.
- Buffers incoming flits per virtual channel and returns a registered per-VC on_off stop signal to the upstream router. The upstream allocator masks its grants with that signal.
- Head flit of each VC is exposed first-word-fall-through to the local allocation stages. The local switch grant pops it.

Parameters:
- VC_NUM, 4, number of virtual channels per port.
- FLIT_W, 64, flit width in bits.
- DEPTH, 8, flit slots per VC; power of two, at least 4.
- OFF_THRESH, 6, occupancy at or above which on_off asserts. Headroom DEPTH-OFF_THRESH covers the link round trip.
- ON_THRESH, 2, occupancy at or below which on_off deasserts. Must be less than OFF_THRESH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  flit valid from link.
- wr_vc  in  $clog2(VC_NUM)  target VC of incoming flit.
- wr_flit  in  FLIT_W  incoming flit.
- rd_en  in  VC_NUM  pop head of VC v (one-hot or multi-hot).
- head_flit  out  VC_NUM x FLIT_W  head flit of each VC.
- head_valid  out  VC_NUM  VC non-empty.
- on_off  out  VC_NUM  1 = stop sending on VC v (to upstream).
- overflow_err  out  1  pulse: write to a full VC was dropped.
- underflow_err  out  1  pulse: pop of an empty VC was ignored.

Behaviour:
- Reset (reset=0, asynchronous):
  - all read/write pointers and counts go to 0;
  - head_valid=0, on_off=0, overflow_err=0, underflow_err=0.
  - head_flit is don't-care while head_valid=0.
  - Reset mid-operation discards all buffered flits.
- Per-VC storage:
  - circular buffer of DEPTH entries;
  - write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH;
  - count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Write:
  - On the rising edge with wr_en=1 and count[wr_vc] < DEPTH, the flit is stored, the write pointer advances and count increments.
  - With wr_en=1 and count[wr_vc] == DEPTH, the flit is dropped and overflow_err=1 for the next cycle.
  - wr_vc >= VC_NUM is treated as overflow.
- Read:
  - head_flit[v] and head_valid[v] are combinational from the current storage and count (FWFT, zero latency).
  - rd_en[v]=1 with count>0 advances the read pointer and decrements count at the edge.
  - rd_en[v]=1 with count==0 is ignored and underflow_err=1 for the next cycle.
- Simultaneous write and read on the same VC:
  - count is unchanged and both pointers advance.
  - This is allowed at count==DEPTH: the read frees the slot the write needs, so it is not an overflow.
  - A write to an empty VC is visible on head_valid the cycle after the edge. It never bypasses combinationally.
- on_off state per VC (registered, hysteresis). Let next_count = count after this edge's updates:
  - OFF → ON_STOP when next_count >= OFF_THRESH.
  - ON_STOP → OFF when next_count <= ON_THRESH.
  - Otherwise hold. on_off[v]=1 in ON_STOP.
  - on_off reflects the updated occupancy one cycle after the edge.
- Error outputs are single-cycle registered pulses. Multiple VCs erroring in one cycle still produce one pulse.
- No combinational path from any input to on_off.

Decomposition:
- Router package holds:
  - VC_NUM and FLIT_W constants;
  - typedef flit_t (logic [FLIT_W-1:0]);
  - typedef vc_id_t (logic [$clog2(VC_NUM)-1:0]).
  - Threshold defaults live as package constants derived from DEPTH and link round-trip latency.
- One sub-module, vc_onoff_fifo: a single-VC FWFT FIFO with count output, full/empty, and the hysteresis on_off register. The top level instantiates it VC_NUM times in a generate loop, decodes wr_vc to per-VC write enables, and ORs the error pulses.

Test Plan:
- Reset then idle: reset low 3 cycles, release. Required: head_valid=0000, on_off=0000 and no error pulses for 10 cycles.
- Fill VC 1: write 6 flits 0x10..0x15 to VC 1, no reads. Required:
  - on_off[1] rises the cycle after the 6th write;
  - head_flit[1]=0x10;
  - other VCs' on_off stay 0.
- Drain hysteresis: continuing from fill, pop VC 1 one flit per cycle. Required:
  - on_off[1] stays 1 at counts 5, 4, 3;
  - on_off[1] drops the cycle after count reaches 2;
  - flits appear in order 0x10..0x15.
- Full boundary: write 8 flits to VC 0, then a 9th (0xFF). Required: overflow_err pulses once and 0xFF never appears on head_flit[0]. Then simultaneous write and pop at count 8: no overflow, count stays 8.
- Empty pop: rd_en=0100 with VC 2 empty. Required: underflow_err pulses once and pointers are unchanged; a subsequent write of 0xAA to VC 2 reads back 0xAA.
- Wrap and async reset: 20 interleaved writes and pops on VC 3 (pointer wrap). Required: order preserved. Then assert reset mid-stream, asynchronously between edges. Required: head_valid and on_off clear immediately, before the next clock edge.
